// File: rtl/ct_spsram_128x104_ctrl.sv
// Controller for a 128x104 single-port SRAM: clears the array after reset, then
// issues in-order read/write requests and buffers read data in a 2-entry response FIFO.
module ct_spsram_128x104_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 104,
    parameter int WE_WIDTH   = 104
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [WE_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic                    init_done_q;
    logic                    rd_pend_q;
    logic [1:0]              cnt_q, cnt_d;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_q [2];

    logic       run, pop, push, acc, rd_acc, rd_ok;
    logic [2:0] occ;

    assign run     = (state_q == ST_RUN);
    assign rsp_vld = (cnt_q != 2'd0);
    assign pop     = rsp_vld & rsp_rdy;
    assign push    = rd_pend_q;

    // Slots already committed (stored + in flight) minus what leaves this cycle;
    // pop implies cnt_q >= 1 so the subtraction never wraps.
    assign occ     = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_ok   = (occ < 3'd2);
    assign req_rdy = run & (req_wr | rd_ok);
    assign acc     = req_vld & req_rdy;
    assign rd_acc  = acc & ~req_wr;

    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign init_done = init_done_q;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (cpurst_b) begin
            if (!run) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = init_cnt_q;
                sram_d    = '0;
            end else if (acc) begin
                sram_cen  = 1'b0;
                sram_gwen = ~req_wr;
                sram_wen  = req_wr ? ~req_wmask : '1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // SRAM Q is valid the cycle after issue, so the capture is keyed off rd_pend_q.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend_q <= 1'b0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            rd_pend_q <= rd_acc;
            cnt_q     <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule
